// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter, LSB first, with a write-side byte FIFO.
// The baud table matches the companion receiver, so one `mode` bus can drive
// both ends of a link. Queued bytes go out back to back with no idle gap.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   mode      baud select: 0=10417, 1=5208, 2=434, 3=195 clk/bit, else 5208
//   data_in   byte to queue, sampled when data_wr=1
//   data_wr   write strobe, one byte per asserted cycle
//   full      FIFO holds FIFO_DEPTH bytes (combinational)
//   busy      frame in progress or bytes queued (combinational)
//   overflow  sticky flag: a write arrived while full
//   tx_line   registered serial output, idles high
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,  // informational; baud table assumes 50 MHz
  parameter int FIFO_DEPTH = 4          // power of two, 2..16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] mode,
  input  logic [7:0] data_in,
  input  logic       data_wr,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       tx_line
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          empty, wr_acc, pop;

  assign full   = (count == (PW+1)'(FIFO_DEPTH));
  assign empty  = (count == '0);
  // full is judged on the pre-pop count, so a write while full is dropped
  // even if the FSM pops on the same edge.
  assign wr_acc = data_wr & ~full;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (data_wr && full) overflow <= 1'b1;
    end
  end

  // ----------------------------------------------------------- baud table
  logic [31:0] len_dec;

  always_comb begin
    case (mode)
      4'd0:    len_dec = 32'd10417;
      4'd1:    len_dec = 32'd5208;
      4'd2:    len_dec = 32'd434;
      4'd3:    len_dec = 32'd195;
      default: len_dec = 32'd5208;
    endcase
  end

  // ------------------------------------------------------------------ FSM
  state_t      state, state_n;
  logic [7:0]  shift, shift_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [31:0] clk_cnt, clk_cnt_n;
  logic [31:0] len_bit, len_bit_n;
  logic        tx_n;
  logic        bit_end;

  // Bit period is latched at each pop, so mode changes never disturb a frame
  // already on the wire.
  assign bit_end = (clk_cnt == len_bit - 32'd1);
  assign busy    = (state != IDLE) || !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      clk_cnt <= '0;
      len_bit <= 32'd5208;
      tx_line <= 1'b1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      clk_cnt <= clk_cnt_n;
      len_bit <= len_bit_n;
      tx_line <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    clk_cnt_n = clk_cnt + 32'd1;
    len_bit_n = len_bit;
    tx_n      = tx_line;
    pop       = 1'b0;

    case (state)
      IDLE: begin
        tx_n      = 1'b1;
        clk_cnt_n = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_n   = mem[rd_ptr];
          len_bit_n = len_dec;
          tx_n      = 1'b0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          tx_n      = shift[0];
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            tx_n      = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          // Chain straight into the next start bit when more data waits.
          if (!empty) begin
            pop       = 1'b1;
            shift_n   = mem[rd_ptr];
            len_bit_n = len_dec;
            tx_n      = 1'b0;
            state_n   = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        tx_n      = 1'b1;
        clk_cnt_n = '0;
        state_n   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mode = 4'd2;
  logic [7:0] data_in = '0;
  logic       data_wr = 1'b0;
  logic       full, busy, overflow, tx_line;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.CLK_FREQ(50000000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .data_in(data_in), .data_wr(data_wr),
    .full(full), .busy(busy), .overflow(overflow), .tx_line(tx_line)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mode;
    logic [7:0] data;
    int         len;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one write strobe; returns at the negedge after the write edge.
  task automatic wr(input logic [7:0] d);
    data_in = d;
    data_wr = 1'b1;
    @(negedge clk);
    data_wr = 1'b0;
  endtask

  // RX model: waits for the start bit, then samples every cycle of ten bit
  // periods of `len` clocks. Each bit's value is taken from its first cycle;
  // any later cycle of that bit differing counts as a glitch (wrong width).
  // Returns at the negedge of the last stop-bit cycle.
  task automatic rx_frame(input int len, output logic [7:0] d,
                          output int idle, output int glitch);
    logic first;
    idle = 0; glitch = 0; d = '0; first = 1'b0;
    @(negedge clk);
    while (tx_line && idle < 60000) begin
      idle++;
      @(negedge clk);
    end
    if (idle >= 60000) begin
      glitch = 999;
      return;
    end
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < len; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (c == 0) begin
          first = tx_line;
          if (b == 0 && first != 1'b0) glitch++;
          if (b == 9 && first != 1'b1) glitch++;
          if (b >= 1 && b <= 8) d[b-1] = first;
        end else if (tx_line != first) begin
          glitch++;
        end
      end
    end
  endtask

  // Length of the current run of `lvl` on tx_line, counting the current sample.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (tx_line == lvl && n < 60000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] d;
    int idle, gl, n, lows;

    tbl[0] = '{4'd2, 8'hA5, 434};
    tbl[1] = '{4'd3, 8'h3C, 195};
    tbl[2] = '{4'd3, 8'h00, 195};
    tbl[3] = '{4'd3, 8'hFF, 195};
    tbl[4] = '{4'd3, 8'h81, 195};

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("reset tx_line", tx_line, 1);
    chk("reset busy", busy, 0);
    chk("reset full", full, 0);
    chk("reset overflow", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- single frames from the table
    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      wr(tbl[i].data);
      rx_frame(tbl[i].len, d, idle, gl);
      chk($sformatf("vec%0d data", i), d, tbl[i].data);
      chk($sformatf("vec%0d bit widths", i), gl, 0);
      chk($sformatf("vec%0d latency", i), idle, 0);
      @(negedge clk);
      chk($sformatf("vec%0d busy after", i), busy, 0);
      chk($sformatf("vec%0d overflow", i), overflow, 0);
      repeat (5) @(negedge clk);
    end

    // ---- back-to-back: three frames, no gap between stop and next start
    mode = 4'd3;
    fork
      begin
        wr(8'h00); wr(8'hFF); wr(8'h55);
      end
      begin
        rx_frame(195, d, idle, gl);
        chk("b2b f0 data", d, 8'h00);
        chk("b2b f0 widths", gl, 0);
        rx_frame(195, d, idle, gl);
        chk("b2b f1 data", d, 8'hFF);
        chk("b2b f1 widths", gl, 0);
        chk("b2b f1 gap", idle, 0);
        rx_frame(195, d, idle, gl);
        chk("b2b f2 data", d, 8'h55);
        chk("b2b f2 widths", gl, 0);
        chk("b2b f2 gap", idle, 0);
      end
    join
    @(negedge clk);
    chk("b2b busy after", busy, 0);
    repeat (5) @(negedge clk);

    // ---- overflow: six writes into a depth-4 FIFO while idle
    fork
      begin
        wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
        chk("ovf full after 4th", full, 0);
        wr(8'h05);
        chk("ovf full after 5th", full, 1);
        chk("ovf flag before 6th", overflow, 0);
        wr(8'h06);
        chk("ovf flag after 6th", overflow, 1);
        chk("ovf full after drop", full, 1);
      end
      begin
        for (int f = 0; f < 5; f++) begin
          rx_frame(195, d, idle, gl);
          chk($sformatf("ovf f%0d data", f), d, f + 1);
          chk($sformatf("ovf f%0d widths", f), gl, 0);
          if (f > 0) chk($sformatf("ovf f%0d gap", f), idle, 0);
        end
      end
    join
    @(negedge clk);
    chk("ovf busy after", busy, 0);
    chk("ovf sticky", overflow, 1);
    repeat (100) @(negedge clk);
    chk("ovf nothing more sent", tx_line, 1);

    // ---- mode latch: 0x3C at 434, mode -> 7 mid-frame, 0xC3 at default 5208
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    chk("ovf cleared by rst", overflow, 0);
    mode = 4'd2;
    wr(8'h3C);
    fork
      begin
        repeat (1000) @(negedge clk);
        mode = 4'd7;
        wr(8'hC3);
      end
      begin
        rx_frame(434, d, idle, gl);
        chk("latch f0 data", d, 8'h3C);
        chk("latch f0 widths", gl, 0);
        @(negedge clk);
        chk("latch f1 contiguous", tx_line, 0);
        run_len(1'b0, n);
        chk("latch f1 start width", n, 5208);
        run_len(1'b1, n);
        chk("latch f1 bits0-1 width", n, 2 * 5208);
      end
    join

    // ---- reset mid-frame
    rst = 1'b1;
    #1;
    chk("rst mid tx_line", tx_line, 1);
    chk("rst mid busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mode = 4'd3;
    wr(8'h11); wr(8'h22); wr(8'h33);
    // Fall happened at the negedge after the first write's edge+1; move to
    // the middle of data bit 4 (bit period index 5).
    repeat (5 * 195 + 97 - 2) @(negedge clk);
    chk("pre-rst busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst bit4 tx_line", tx_line, 1);
    chk("rst bit4 busy", busy, 0);
    chk("rst bit4 full", full, 0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (3000) begin
      @(negedge clk);
      if (!tx_line) lows++;
    end
    chk("no frames after rst", lows, 0);
    wr(8'h5A);
    rx_frame(195, d, idle, gl);
    chk("post-rst data", d, 8'h5A);
    chk("post-rst widths", gl, 0);
    chk("post-rst latency", idle, 0);
    @(negedge clk);
    chk("post-rst busy after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
